// File: rtl/mobo.sv
// mobo: single-transaction memory/bus controller with a word-addressed RAM
// and a wait-state FSM (IDLE -> [WAIT] -> ACCESS -> DONE -> IDLE).
module mobo #(
    parameter int unsigned word_width  = 32,
    parameter int unsigned addr_width  = 8,
    parameter int unsigned wait_states = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [word_width-1:0] mobo_ctrl,
    output logic [word_width-1:0] mobo_stat,
    input  logic [word_width-1:0] addr,
    input  logic [word_width-1:0] data_wr,
    output logic [word_width-1:0] data_rd
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << addr_width;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [word_width-1:0] data_q, data_d;
    logic                  op_q, op_d;
    logic                  err_q, err_d;
    logic [word_width-1:0] data_rd_q, data_rd_d;
    logic [word_width-1:0] stat_q, stat_d;

    logic                  mem_we;
    logic [word_width-1:0] mem_rdata;
    logic [word_width-1:0] mem [DEPTH];

    logic                  req;
    logic                  req_bad;
    logic                  unused_ctrl;

    // Only the two low request bits carry meaning.
    assign unused_ctrl = ^mobo_ctrl[word_width-1:2];

    assign req       = mobo_ctrl[0] | mobo_ctrl[1];
    assign req_bad   = (mobo_ctrl[0] & mobo_ctrl[1]) | ((addr >> addr_width) != '0);
    assign mem_rdata = mem[addr_q];

    // Next-state, latched request and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        op_d      = op_q;
        err_d     = err_q;
        data_rd_d = data_rd_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = addr[addr_width-1:0];
                    data_d = data_wr;
                    op_d   = mobo_ctrl[1];
                    err_d  = req_bad;
                    if (req_bad) begin
                        state_d = S_DONE;
                    end else if (wait_states > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(wait_states);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (op_q) begin
                    mem_we = 1'b1;
                end else begin
                    data_rd_d = mem_rdata;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stat_d    = '0;
        stat_d[0] = (state_d != S_IDLE);
        stat_d[1] = (state_d == S_DONE);
        stat_d[2] = err_d;
        stat_d[3] = op_d;
    end

    // Control and output registers; async reset returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            op_q      <= 1'b0;
            err_q     <= 1'b0;
            data_rd_q <= '0;
            stat_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            op_q      <= op_d;
            err_q     <= err_d;
            data_rd_q <= data_rd_d;
            stat_q    <= stat_d;
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign mobo_stat = stat_q;
    assign data_rd   = data_rd_q;

endmodule

// File: tb/tb_mobo.sv
// tb_mobo: directed checks of mobo with wait_states=2 and wait_states=0.
module tb_mobo;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl2, addr2, wr2, stat2, rd2;
    logic [31:0] ctrl0, addr0, wr0, stat0, rd0;

    int checks;
    int errors;

    mobo #(.word_width(32), .addr_width(8), .wait_states(2)) u_w2 (
        .clk(clk), .rst(rst), .mobo_ctrl(ctrl2), .mobo_stat(stat2),
        .addr(addr2), .data_wr(wr2), .data_rd(rd2)
    );

    mobo #(.word_width(32), .addr_width(8), .wait_states(0)) u_w0 (
        .clk(clk), .rst(rst), .mobo_ctrl(ctrl0), .mobo_stat(stat0),
        .addr(addr0), .data_wr(wr0), .data_rd(rd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request on the W=2 instance, let edge E0 sample it, then drop it.
    task automatic req2(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
        ctrl2 = c; addr2 = a; wr2 = d;
        cyc(1);
        ctrl2 = 32'h0;
    endtask

    task automatic req0(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
        ctrl0 = c; addr0 = a; wr0 = d;
        cyc(1);
        ctrl0 = 32'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ctrl2 = '0; addr2 = '0; wr2 = '0;
        ctrl0 = '0; addr0 = '0; wr0 = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_stat", stat2, 32'h0);
        chk("reset_rd", rd2, 32'h0);
        cyc(2);
        #2 rst = 1'b0;
        cyc(1);
        chk("idle_stat", stat2, 32'h0);

        // W=2 write DEADBEEF to 5
        req2(32'h2, 32'd5, 32'hDEADBEEF);
        chk("wr_busy_e0", stat2, 32'h9);
        cyc(2);
        chk("wr_wait_e2", stat2, 32'h9);
        cyc(1);
        chk("wr_ready_e3", stat2, 32'hB);
        cyc(1);
        chk("wr_idle_e4", stat2, 32'h8);

        // W=2 read of 5
        req2(32'h1, 32'd5, 32'h0);
        chk("rd_busy_e0", stat2, 32'h1);
        cyc(2);
        chk("rd_notyet_e2", rd2, 32'h0);
        cyc(1);
        chk("rd_ready_e3", stat2, 32'h3);
        chk("rd_data_e3", rd2, 32'hDEADBEEF);
        cyc(1);
        chk("rd_idle_e4", stat2, 32'h0);
        chk("rd_hold_e4", rd2, 32'hDEADBEEF);

        // W=0: seed addr 0, write 255, read both back
        req0(32'h2, 32'd0, 32'hCAFEF00D);
        cyc(2);
        req0(32'h2, 32'd255, 32'h12345678);
        chk("w0_wr_e0", stat0, 32'h9);
        cyc(1);
        chk("w0_wr_ready_e1", stat0, 32'hB);
        cyc(1);
        chk("w0_wr_idle_e2", stat0, 32'h8);
        req0(32'h1, 32'd255, 32'h0);
        cyc(1);
        chk("w0_rd_ready_e1", stat0, 32'h3);
        chk("w0_rd_data_255", rd0, 32'h12345678);
        cyc(1);
        req0(32'h1, 32'd0, 32'h0);
        cyc(1);
        chk("w0_rd_data_0", rd0, 32'hCAFEF00D);
        cyc(1);

        // Address out of range
        req2(32'h1, 32'd256, 32'h0);
        chk("err_addr_e0", stat2, 32'h7);
        chk("err_addr_rd", rd2, 32'hDEADBEEF);
        cyc(1);
        chk("err_addr_idle", stat2, 32'h4);

        // Both request bits set; RAM[5] must survive
        req2(32'h3, 32'd5, 32'h55555555);
        chk("err_both_e0", stat2, 32'hF);
        cyc(1);
        chk("err_both_idle", stat2, 32'hC);
        req2(32'h1, 32'd5, 32'h0);
        chk("err_cleared", stat2, 32'h1);
        cyc(3);
        chk("err_both_ram", rd2, 32'hDEADBEEF);
        cyc(1);

        // Held request re-accepted on the IDLE edge; WAIT pulse ignored
        ctrl2 = 32'h1; addr2 = 32'd5;
        cyc(4);
        chk("held_ready", stat2, 32'h3);
        cyc(1);
        chk("held_idle", stat2, 32'h0);
        cyc(1);
        chk("held_reaccept", stat2, 32'h1);
        ctrl2 = 32'h2; addr2 = 32'd9; wr2 = 32'h99;
        cyc(1);
        ctrl2 = 32'h0;
        chk("pulse_wait", stat2, 32'h1);
        cyc(2);
        chk("pulse_done_op", stat2, 32'h3);
        cyc(2);
        chk("pulse_no_txn", stat2, 32'h0);

        // Reset during WAIT of a write
        req2(32'h2, 32'd7, 32'h1111);
        cyc(4);
        req2(32'h2, 32'd7, 32'hAAAA);
        cyc(1);
        #2 rst = 1'b1;
        #1;
        chk("rst_wait_stat", stat2, 32'h0);
        chk("rst_wait_rd", rd2, 32'h0);
        #2 rst = 1'b0;
        cyc(1);
        req2(32'h1, 32'd7, 32'h0);
        cyc(3);
        chk("rst_wait_ram", rd2, 32'h1111);
        chk("rst_wait_rd_stat", stat2, 32'h3);
        cyc(1);

        // Reset during DONE of a read, then a normal read
        req2(32'h1, 32'd7, 32'h0);
        cyc(3);
        chk("rst_done_pre", stat2, 32'h3);
        #2 rst = 1'b1;
        #1;
        chk("rst_done_stat", stat2, 32'h0);
        #1 rst = 1'b0;
        cyc(1);
        chk("rst_done_idle", stat2, 32'h0);
        req2(32'h1, 32'd5, 32'h0);
        cyc(3);
        chk("post_rst_rd", rd2, 32'hDEADBEEF);
        chk("post_rst_stat", stat2, 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
